// File: rtl/alu_ctrl.sv
// Push-button front end for a small ALU: synchronizes and debounces three buttons,
// loads one operand/control register per accepted press, then captures the ALU result.
module alu_ctrl #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   SWITCH,
    input  logic         B0,
    input  logic         B1,
    input  logic         B2,
    input  logic [N-1:0] RES_in,
    input  logic [3:0]   FC_in,
    output logic [N-1:0] A_reg,
    output logic [N-1:0] B_reg,
    output logic [9:0]   C_reg,
    output logic [N-1:0] RES_q,
    output logic [3:0]   FC_q,
    output logic         res_valid,
    output logic         busy
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_CAPTURE  = 3'd4;
    localparam logic [2:0] ST_WAIT_REL = 3'd5;

    localparam logic [2:0] SEL_A = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_C = 3'b100;

    logic [2:0]    meta_q, sync_q;
    logic [2:0]    sel;
    logic          sel_legal;
    logic [2:0]    state_q, state_d;
    logic [2:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [9:0]    c_q, c_d;
    logic [3:0]    fc_q, fc_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    // Buttons idle high, so the synchronizer resets to "released" and sel reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 3'b111;
            sync_q <= 3'b111;
        end else begin
            meta_q <= {B2, B1, B0};
            sync_q <= meta_q;
        end
    end

    assign sel       = ~sync_q;
    assign sel_legal = (sel == SEL_A) || (sel == SEL_B) || (sel == SEL_C);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        fc_d    = fc_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_legal) begin
                    state_d = ST_DEBOUNCE;
                    pend_d  = sel;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (sel != pend_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LOAD: begin
                case (pend_q)
                    SEL_A:   a_d = SWITCH[N-1:0];
                    SEL_B:   b_d = SWITCH[N-1:0];
                    SEL_C:   c_d = SWITCH;
                    default: ;
                endcase
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_d   = RES_in;
                fc_d    = FC_in;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // Any non-zero sample, legal or not, restarts the release window.
                if (sel != 3'b000) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            fc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            fc_q    <= fc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign A_reg     = a_q;
    assign B_reg     = b_q;
    assign C_reg     = c_q;
    assign RES_q     = res_q;
    assign FC_q      = fc_q;
    assign res_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a short debounce window; expected values are hand-computed.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] SWITCH;
    logic       B0, B1, B2;
    logic [3:0] RES_in;
    logic [3:0] FC_in;
    logic [3:0] A_reg, B_reg, RES_q, FC_q;
    logic [9:0] C_reg;
    logic       res_valid, busy;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int rv_base;

    alu_ctrl #(.N(4), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .SWITCH(SWITCH),
        .B0(B0), .B1(B1), .B2(B2),
        .RES_in(RES_in), .FC_in(FC_in),
        .A_reg(A_reg), .B_reg(B_reg), .C_reg(C_reg),
        .RES_q(RES_q), .FC_q(FC_q),
        .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in: op = C[1:0] (add/sub/and/xor); C[4] enables the signed flags v and n.
    logic [4:0] sum;
    logic [3:0] alu_r;
    logic       alu_c, alu_v;
    always_comb begin
        sum   = 5'd0;
        alu_r = 4'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (C_reg[1:0])
            2'd0: begin
                sum   = {1'b0, A_reg} + {1'b0, B_reg};
                alu_r = sum[3:0];
                alu_c = sum[4];
                alu_v = (A_reg[3] == B_reg[3]) && (alu_r[3] != A_reg[3]);
            end
            2'd1: begin
                alu_r = A_reg - B_reg;
                alu_c = (A_reg < B_reg);
                alu_v = (A_reg[3] != B_reg[3]) && (alu_r[3] != A_reg[3]);
            end
            2'd2:    alu_r = A_reg & B_reg;
            default: alu_r = A_reg ^ B_reg;
        endcase
        RES_in = alu_r;
        FC_in  = {alu_r == 4'd0, C_reg[4] & alu_v, alu_c, C_reg[4] & alu_r[3]};
    end

    always @(negedge clk) if (res_valid === 1'b1) rv_cnt <= rv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 32'h0);
        cyc(3);
    endtask

    task automatic press(input int btn, input logic [9:0] sw, input int hold);
        SWITCH = sw;
        if (btn == 0) B0 = 1'b0;
        if (btn == 1) B1 = 1'b0;
        if (btn == 2) B2 = 1'b0;
        cyc(hold);
        B0 = 1'b1;
        B1 = 1'b1;
        B2 = 1'b1;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        SWITCH = 10'h3FF;
        B0 = 1'b1; B1 = 1'b1; B2 = 1'b1;
        cyc(3);
        chk("reset_outputs", {A_reg, B_reg, C_reg, RES_q, FC_q, res_valid, busy}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {A_reg, B_reg, C_reg, RES_q, FC_q, res_valid, busy}, 32'h0);
        end

        // A load: update on edge 7 after first sampling, res_valid two edges later.
        rv_base = rv_cnt;
        SWITCH = 10'h005;
        B0 = 1'b0;
        cyc(7);
        chk("a_before_edge7", 32'(A_reg), 32'h0);
        cyc(1);
        chk("a_at_edge7", 32'(A_reg), 32'h5);
        chk("rv_low_at_load", 32'(res_valid), 32'h0);
        cyc(1);
        chk("rv_low_exec", 32'(res_valid), 32'h0);
        cyc(1);
        chk("rv_pulse", 32'(res_valid), 32'h1);
        chk("res_a_only", 32'(RES_q), 32'h5);
        chk("fc_a_only", 32'(FC_q), 32'h0);
        cyc(1);
        chk("rv_one_cycle", 32'(res_valid), 32'h0);
        cyc(1);
        B0 = 1'b1;
        wait_idle();
        chk("a_single_load", rv_cnt - rv_base, 32'd1);
        chk("a_held", 32'(A_reg), 32'h5);

        // C = add, then B = 3: 5 + 3.
        press(2, 10'h000, 12);
        chk("c_add", 32'(C_reg), 32'h000);
        press(1, 10'h003, 12);
        chk("b_load", 32'(B_reg), 32'h3);
        chk("res_add", 32'(RES_q), 32'h8);
        chk("fc_add", 32'(FC_q), 32'h0);

        // Signed add: 5 + 3 overflows, v and n set.
        press(2, 10'h010, 12);
        chk("c_signed", 32'(C_reg), 32'h010);
        chk("res_signed", 32'(RES_q), 32'h8);
        chk("fc_signed", 32'(FC_q), 32'h5);

        // Upper switch bits are ignored for operand loads.
        press(0, 10'h3F7, 12);
        chk("a_upper_ignored", 32'(A_reg), 32'h7);
        chk("res_7p3", 32'(RES_q), 32'hA);

        // Bounce: five 2-cycle phases, last one continues as a stable press.
        rv_base = rv_cnt;
        SWITCH = 10'h009;
        for (int i = 0; i < 5; i++) begin
            B0 = (i % 2 == 1) ? 1'b1 : 1'b0;
            cyc(2);
        end
        chk("bounce_no_load", 32'(A_reg), 32'h7);
        chk("bounce_no_rv", rv_cnt - rv_base, 32'd0);
        cyc(12);
        B0 = 1'b1;
        wait_idle();
        chk("bounce_one_load", rv_cnt - rv_base, 32'd1);
        chk("bounce_a", 32'(A_reg), 32'h9);
        chk("res_9p3", 32'(RES_q), 32'hC);
        chk("fc_9p3", 32'(FC_q), 32'h1);

        // Two buttons at once are illegal.
        rv_base = rv_cnt;
        SWITCH = 10'h3FF;
        B0 = 1'b0;
        B1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("dual_busy", 32'(busy), 32'h0);
        end
        B0 = 1'b1;
        B1 = 1'b1;
        cyc(4);
        chk("dual_regs", {A_reg, B_reg, C_reg}, {14'h0, 4'h9, 4'h3, 10'h010});
        chk("dual_no_rv", rv_cnt - rv_base, 32'd0);

        // Reset during DEBOUNCE with C held, then the held button is a fresh press.
        SWITCH = 10'h155;
        B2 = 1'b0;
        cyc(4);
        chk("c_debouncing", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_regs", {A_reg, B_reg, C_reg, RES_q, FC_q}, 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        cyc(2);
        chk("rst_c_zero", 32'(C_reg), 32'h0);
        rst_n = 1'b1;
        cyc(7);
        chk("c_before_reload", 32'(C_reg), 32'h0);
        cyc(1);
        chk("c_reload", 32'(C_reg), 32'h155);
        cyc(2);
        chk("rst_rv_pulse", 32'(res_valid), 32'h1);
        chk("res_sub0", 32'(RES_q), 32'h0);
        chk("fc_sub0", 32'(FC_q), 32'h8);
        cyc(4);
        B2 = 1'b1;
        wait_idle();
        chk("c_single_load", 32'(C_reg), 32'h155);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter N, default 4: ALU operand width, legal 1..10.
REQ-002 Parameter DB_CYCLES, default 250000: debounce stable-sample count, minimum 2.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SWITCH  input  10  raw switch bank; static while a button is held.
REQ-006 B0, B1, B2  input  1 each  raw push-buttons, active-low, asynchronous to clk, bouncing.
REQ-007 RES_in  input  N  ALU result, combinational from A_reg/B_reg/C_reg.
REQ-008 FC_in  input  4  ALU flags {z,v,c,n}, combinational.
REQ-009 A_reg, B_reg  output  N each  ALU operand registers.
REQ-010 C_reg  output  10  ALU/display control register; field layout unchanged from top level.
REQ-011 RES_q  output  N  captured ALU result.
REQ-012 FC_q  output  4  captured flags.
REQ-013 res_valid  output  1  one-cycle pulse when RES_q/FC_q update.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Synchronized pattern sel = {~B2,~B1,~B0}; legal press SHALL be exactly one bit set (001=A, 010=B, 100=C); all other non-zero patterns are illegal.
REQ-017 States SHALL be IDLE, DEBOUNCE, LOAD, EXEC, CAPTURE, WAIT_REL.
REQ-018 IDLE: legal sel -> DEBOUNCE, latch sel into pend, clear counter; zero or illegal sel -> stay.
REQ-019 DEBOUNCE: each cycle sel == pend increments counter; on counter reaching DB_CYCLES-1 -> LOAD; any sel != pend -> IDLE without loading.
REQ-020 LOAD (one cycle): pend=A loads A_reg <= SWITCH[N-1:0]; pend=B loads B_reg <= SWITCH[N-1:0]; pend=C loads C_reg <= SWITCH[9:0]; SWITCH[9:N] ignored for A/B; -> EXEC.
REQ-021 EXEC (one cycle): settle slot, no register writes; -> CAPTURE.
REQ-022 CAPTURE (one cycle): RES_q <= RES_in, FC_q <= FC_in, res_valid = 1 this cycle only; -> WAIT_REL.
REQ-023 WAIT_REL: sel must read 000 for DB_CYCLES consecutive cycles -> IDLE; any non-zero sample restarts count; new presses SHALL NOT load until IDLE is reached.
REQ-024 Latency: selected register updates at the clock edge ending LOAD, 2 + DB_CYCLES + 1 edges after the raw press is first sampled; res_valid high 2 cycles after that update.
REQ-025 Exactly one register written per accepted press; holding a button SHALL never cause a repeat load.
REQ-026 Counter width clog2(DB_CYCLES)+1; it SHALL saturate, never wrap.
REQ-027 All outputs registered; no combinational path from B0..B2 or SWITCH to any output.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE and A_reg, B_reg, C_reg, RES_q, FC_q, counter, pend and synchronizers to 0; res_valid and busy to 0.
REQ-029 Reset asserted mid-DEBOUNCE or mid-LOAD SHALL abort with no register written; after release, a still-held button SHALL be treated as a new press.
REQ-030 Synchronizer flops SHALL reset to the released value (1), so no press is seen for the first 2 cycles after reset.

Verification (DB_CYCLES=4, N=4)
REQ-031 Reset release, SWITCH=0x3FF, no buttons -> all outputs 0, busy 0 for 20 cycles.
REQ-032 SWITCH=0x005, B0 low 12 cycles -> A_reg=0x5 at edge 7 after press, res_valid pulse 2 cycles later, single load only.
REQ-033 C_reg loaded 0x000 (add), A=0x5, then SWITCH=0x003 press B1 -> B_reg=0x3, RES_q=0x8, FC_q=0000.
REQ-034 B0 bouncing low/high every 2 cycles for 10 cycles then stable low -> exactly one load after the stable window; none during bounce.
REQ-035 B0 and B1 held together -> no register changes, busy stays 0.
REQ-036 rst_n pulsed low during DEBOUNCE with B2 held -> C_reg stays 0 through reset, loads SWITCH once after reset release plus 2+DB_CYCLES+1 cycles.
